shift_op_reg: RTL and testbench

SHIFT_OP_REG -- requirements
Module: shift_op_reg

---
 rtl/shift_op_pkg.sv | 31 +++
 rtl/shift_op_step.sv | 26 ++
 rtl/shift_op_reg.sv | 102 ++++++++++
 tb/tb_shift_op_reg.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shift_op_pkg.sv
// Shared types for the multi-op shift register.
// Holds the opcode encoding and the FSM states.
package shift_op_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_COMP  = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_ROR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic [2:0] {
        LOAD  = OP_LOAD,
        COMP  = OP_COMP,
        SHR   = OP_SHR,
        SHL   = OP_SHL,
        ROR   = OP_ROR,
        ROL   = OP_ROL,
        ASR   = OP_ASR,
        CLEAR = OP_CLEAR
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_op_step.sv
// One single-bit step of a shift/rotate op.
// Non-shift ops pass the register through unchanged.
module shift_op_step
    import shift_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] dout,
    input  logic             ser_in,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = dout;
        unique case (op)
            SHR:     nxt = {ser_in, dout[WIDTH-1:1]};
            SHL:     nxt = {dout[WIDTH-2:0], ser_in};
            ROR:     nxt = {dout[0], dout[WIDTH-1:1]};
            ROL:     nxt = {dout[WIDTH-2:0], dout[WIDTH-1]};
            ASR:     nxt = {dout[WIDTH-1], dout[WIDTH-1:1]};
            default: nxt = dout;
        endcase
    end

endmodule

// File: rtl/shift_op_reg.sv
// Register with load/complement/clear and multi-cycle shifts.
// Shifts run one bit per cycle under a small three-state FSM.
module shift_op_reg
    import shift_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_in,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_val;

    shift_op_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op     (op_q),
        .dout   (dout_q),
        .ser_in (ser_in),
        .nxt    (step_val)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op_t'(op);
                    cnt_d = amount;
                    unique case (op_t'(op))
                        LOAD: begin
                            dout_d  = din;
                            state_d = DONE;
                        end
                        COMP: begin
                            dout_d  = ~dout_q;
                            state_d = DONE;
                        end
                        CLEAR: begin
                            dout_d  = '0;
                            state_d = DONE;
                        end
                        default: begin
                            state_d = (amount == '0) ? DONE : SHIFT;
                        end
                    endcase
                end
            end
            SHIFT: begin
                dout_d = step_val;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status flags are registered copies of the next state.
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= LOAD;
            cnt_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shift_op_reg.sv
// Directed self-checking bench for shift_op_reg at WIDTH=8.
// Samples 1 time unit after each rising edge.
module tb_shift_op_reg;
    import shift_op_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] din;
    logic             ser_in;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    shift_op_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .amount (amount),
        .din    (din),
        .ser_in (ser_in),
        .dout   (dout),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [2:0] o, input logic [CNT_W-1:0] a,
                      input logic [WIDTH-1:0] d);
        start  = 1'b1;
        op     = o;
        amount = a;
        din    = d;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b1;
        op     = OP_LOAD;
        amount = '0;
        din    = 8'hFF;
        ser_in = 1'b0;
        tick();
        tick();
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_cnt", 32'(dut.cnt_q), 32'h0);

        // first edge with reset released accepts the LOAD
        reset = 1'b1;
        go(OP_LOAD, 4'd0, 8'hB4);
        chk("load_dout", 32'(dout), 32'hB4);
        chk("load_done", 32'(done), 32'h1);
        chk("load_busy", 32'(busy), 32'h0);
        tick();
        chk("load_done_off", 32'(done), 32'h0);

        go(OP_ROL, 4'd3, 8'h00);
        chk("rol_b0", 32'(busy), 32'h1);
        chk("rol_d0", 32'(dout), 32'hB4);
        chk("rol_n0", 32'(done), 32'h0);
        tick();
        chk("rol_b1", 32'(busy), 32'h1);
        chk("rol_d1", 32'(dout), 32'h69);
        tick();
        chk("rol_b2", 32'(busy), 32'h1);
        chk("rol_d2", 32'(dout), 32'hD2);
        tick();
        chk("rol_b3", 32'(busy), 32'h0);
        chk("rol_d3", 32'(dout), 32'hA5);
        chk("rol_done", 32'(done), 32'h1);
        tick();
        chk("rol_done_off", 32'(done), 32'h0);

        go(OP_LOAD, 4'd0, 8'h0F);
        tick();
        ser_in = 1'b1;
        go(OP_SHR, 4'd4, 8'h00);
        // inputs and start toggled mid-shift must be ignored
        op     = OP_CLEAR;
        amount = 4'd1;
        din    = 8'h55;
        start  = 1'b1;
        tick();
        chk("shr_d1", 32'(dout), 32'h87);
        start = 1'b0;
        tick();
        tick();
        chk("shr_b3", 32'(busy), 32'h1);
        chk("shr_n3", 32'(done), 32'h0);
        chk("shr_d3", 32'(dout), 32'hE1);
        tick();
        chk("shr_dout", 32'(dout), 32'hF0);
        chk("shr_done", 32'(done), 32'h1);
        chk("shr_busy", 32'(busy), 32'h0);
        tick();
        chk("shr_idle", 32'(dut.state_q), 32'(IDLE));
        ser_in = 1'b0;

        go(OP_LOAD, 4'd0, 8'h90);
        tick();
        go(OP_ASR, 4'd2, 8'h00);
        tick();
        chk("asr_d1", 32'(dout), 32'hC8);
        tick();
        chk("asr_dout", 32'(dout), 32'hE4);
        chk("asr_done", 32'(done), 32'h1);
        tick();
        go(OP_COMP, 4'd0, 8'h00);
        chk("comp_dout", 32'(dout), 32'h1B);
        chk("comp_done", 32'(done), 32'h1);
        tick();

        go(OP_SHL, 4'd0, 8'h00);
        chk("shl0_done", 32'(done), 32'h1);
        chk("shl0_busy", 32'(busy), 32'h0);
        chk("shl0_dout", 32'(dout), 32'h1B);
        tick();
        chk("shl0_idle", 32'(done), 32'h0);

        // amount above WIDTH runs literally: 9 rotates of 0x01
        go(OP_LOAD, 4'd0, 8'h01);
        tick();
        go(OP_ROL, 4'd9, 8'h00);
        for (int i = 0; i < 8; i++) tick();
        chk("rol9_b8", 32'(busy), 32'h1);
        chk("rol9_d8", 32'(dout), 32'h01);
        tick();
        chk("rol9_dout", 32'(dout), 32'h02);
        chk("rol9_done", 32'(done), 32'h1);
        tick();

        go(OP_LOAD, 4'd0, 8'h1B);
        tick();
        go(OP_ROR, 4'd5, 8'h00);
        tick();
        chk("ror_d1", 32'(dout), 32'h8D);
        chk("ror_b1", 32'(busy), 32'h1);
        reset = 1'b0;
        tick();
        chk("mid_rst_dout", 32'(dout), 32'h00);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("mid_rst_cnt", 32'(dut.cnt_q), 32'h0);
        reset = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
